// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational ALU between two requesters,
// with a registered operand stage, a valid/ready response channel and a saturating overflow count.
module alu_share_ctrl #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_select,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_select,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_select,
   input  logic [WIDTH-1:0] alu_s,
   input  logic             alu_overflow,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_overflow,
   output logic             resp_id,
   output logic [CNT_W-1:0] ovf_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state_q, state_d;
   logic last_grant_q, last_grant_d;
   logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, resp_data_q, resp_data_d;
   logic [1:0] op_sel_q, op_sel_d;
   logic op_id_q, op_id_d;
   logic resp_valid_q, resp_valid_d, resp_ovf_q, resp_ovf_d, resp_id_q, resp_id_d;
   logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
   logic grant0, grant1;
   // on a tie the requester that did not win last time is granted
   assign grant0 = req0_valid & (~req1_valid | last_grant_q);
   assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
   assign req0_ready = ~reset & (state_q == IDLE) & grant0;
   assign req1_ready = ~reset & (state_q == IDLE) & grant1;
   assign alu_a = op_a_q;
   assign alu_b = op_b_q;
   assign alu_select = op_sel_q;
   assign resp_valid = resp_valid_q;
   assign resp_data = resp_data_q;
   assign resp_overflow = resp_ovf_q;
   assign resp_id = resp_id_q;
   assign ovf_count = ovf_count_q;
   always_comb begin
      state_d = state_q;
      last_grant_d = last_grant_q;
      op_a_d = op_a_q;
      op_b_d = op_b_q;
      op_sel_d = op_sel_q;
      op_id_d = op_id_q;
      resp_valid_d = resp_valid_q;
      resp_data_d = resp_data_q;
      resp_ovf_d = resp_ovf_q;
      resp_id_d = resp_id_q;
      ovf_count_d = ovf_count_q;
      if (req0_ready || req1_ready) begin
         op_a_d = grant1 ? req1_a : req0_a;
         op_b_d = grant1 ? req1_b : req0_b;
         op_sel_d = grant1 ? req1_select : req0_select;
         op_id_d = grant1;
         last_grant_d = grant1;
         state_d = EXEC;
      end else if (state_q == EXEC) begin
         // the ALU leaves its overflow flag stale for AND/XOR, so it only counts for ADD/SUB
         resp_data_d = alu_s;
         resp_id_d = op_id_q;
         resp_ovf_d = alu_overflow & ~op_sel_q[1];
         ovf_count_d = ovf_count_q + CNT_W'(resp_ovf_d & ~&ovf_count_q);
         resp_valid_d = 1'b1;
         state_d = RESP;
      end else if (state_q == RESP && resp_ready) begin
         resp_valid_d = 1'b0;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_grant_q <= 1'b1;
         op_a_q <= '0;
         op_b_q <= '0;
         op_sel_q <= '0;
         op_id_q <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q <= '0;
         resp_ovf_q <= 1'b0;
         resp_id_q <= 1'b0;
         ovf_count_q <= '0;
      end else begin
         state_q <= state_d;
         last_grant_q <= last_grant_d;
         op_a_q <= op_a_d;
         op_b_q <= op_b_d;
         op_sel_q <= op_sel_d;
         op_id_q <= op_id_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q <= resp_data_d;
         resp_ovf_q <= resp_ovf_d;
         resp_id_q <= resp_id_d;
         ovf_count_q <= ovf_count_d;
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vector table plus hand-written arbitration, backpressure and reset sequences.
module tb_alu_share_ctrl;
   localparam int W = 64;
   localparam int CW = 2;
   logic clk = 1'b0, reset;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_s, resp_data;
   logic [1:0] req0_select, req1_select, alu_select;
   logic alu_overflow, resp_valid, resp_ready, resp_overflow, resp_id;
   logic [CW-1:0] ovf_count;
   int errors = 0, checks = 0;

   alu_share_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_select(req0_select),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_select(req1_select),
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_s(alu_s), .alu_overflow(alu_overflow),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_overflow(resp_overflow), .resp_id(resp_id), .ovf_count(ovf_count));

   always #5 clk = ~clk;

   // shared ALU; for AND/XOR the flag is left stale, modelled here as a worst-case 1
   always_comb begin
      alu_s = alu_a + alu_b;
      alu_overflow = (alu_a[63] == alu_b[63]) && (alu_s[63] != alu_a[63]);
      if (alu_select == 2'b01) begin
         alu_s = alu_a - alu_b;
         alu_overflow = (alu_a[63] != alu_b[63]) && (alu_s[63] != alu_a[63]);
      end else if (alu_select == 2'b10) begin
         alu_s = alu_a & alu_b;
         alu_overflow = 1'b1;
      end else if (alu_select == 2'b11) begin
         alu_s = alu_a ^ alu_b;
         alu_overflow = 1'b1;
      end
   end

   typedef struct {
      logic          id;
      logic [W-1:0]  a, b;
      logic [1:0]    sel;
      logic [W-1:0]  data;
      logic          ovf;
      logic [CW-1:0] cnt;
   } vec_t;
   vec_t tv[8];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
      if (id) begin
         req1_valid = v; req1_a = a; req1_b = b; req1_select = sel;
      end else begin
         req0_valid = v; req0_a = a; req0_b = b; req0_select = sel;
      end
   endtask

   task automatic wait_grant(output logic r);
      int n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 8) begin
         @(negedge clk); #1; n++;
      end
      chk("grant_seen", req0_ready | req1_ready, 1);
      chk("grant_onehot", req0_ready & req1_ready, 0);
      r = req1_ready;
   endtask

   task automatic do_op(input vec_t v);
      logic r;
      set_req(v.id, 1'b1, v.a, v.b, v.sel);
      wait_grant(r);
      chk("grant_id", r, v.id);
      @(negedge clk); #1;
      chk("exec_no_valid", resp_valid, 0);
      chk("exec_operand_a", alu_a, v.a);
      chk("exec_no_ready", req0_ready | req1_ready, 0);
      @(negedge clk); #1;
      chk("resp_valid", resp_valid, 1);
      chk("resp_data", resp_data, v.data);
      chk("resp_overflow", resp_overflow, v.ovf);
      chk("resp_id", resp_id, v.id);
      chk("ovf_count", ovf_count, v.cnt);
      set_req(v.id, 1'b0, v.a, v.b, v.sel);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic r;
      logic [W-1:0] cur_a[2], exp_d;
      tv[0] = '{1'b0, 64'd5, 64'd7, 2'b00, 64'd12, 1'b0, 2'd0};
      tv[1] = '{1'b1, 64'h8000_0000_0000_0000, 64'd1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 2'd1};
      tv[2] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h8000_0000_0000_0000, 1'b1, 2'd2};
      tv[3] = '{1'b1, 64'hF0, 64'h3C, 2'b10, 64'h30, 1'b0, 2'd2};
      tv[4] = '{1'b0, 64'hFF, 64'h0F, 2'b11, 64'hF0, 1'b0, 2'd2};
      tv[5] = '{1'b1, 64'd3, 64'd5, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2'd2};
      tv[6] = '{1'b0, 64'h8000_0000_0000_0000, 64'd2, 2'b01, 64'h7FFF_FFFF_FFFF_FFFE, 1'b1, 2'd3};
      tv[7] = '{1'b1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 2'b00, 64'h8000_0000_0000_0000, 1'b1, 2'd3};
      reset = 1'b1; resp_ready = 1'b1;
      set_req(1'b0, 1'b1, 64'd1, 64'd1, 2'b00);
      set_req(1'b1, 1'b0, 64'd0, 64'd0, 2'b00);
      repeat (2) @(negedge clk);
      #1 chk("ready_in_reset", req0_ready, 0);
      @(negedge clk);
      reset = 1'b0; req0_valid = 1'b0;
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_ovf", resp_overflow, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_ovf_count", ovf_count, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_select", alu_select, 0);
      for (int i = 0; i < 8; i++) do_op(tv[i]);

      // fairness: both requesters stay valid, payload advances after each grant
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      cur_a[0] = 64'h100; cur_a[1] = 64'h200;
      set_req(1'b0, 1'b1, cur_a[0], 64'd1, 2'b00);
      set_req(1'b1, 1'b1, cur_a[1], 64'd1, 2'b00);
      for (int k = 0; k < 8; k++) begin
         wait_grant(r);
         chk("fair_grant", r, k % 2);
         exp_d = cur_a[r] + 64'd1;
         @(negedge clk);
         cur_a[r] = cur_a[r] + 64'd16;
         set_req(r, 1'b1, cur_a[r], 64'd1, 2'b00);
         @(negedge clk); #1;
         chk("fair_resp_valid", resp_valid, 1);
         chk("fair_resp_id", resp_id, k % 2);
         chk("fair_resp_data", resp_data, exp_d);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // backpressure: response held, no grants while stalled
      @(negedge clk);
      resp_ready = 1'b0;
      set_req(1'b0, 1'b1, 64'hFF, 64'h0F, 2'b11);
      set_req(1'b1, 1'b1, 64'hF0, 64'h3C, 2'b10);
      #1 chk("bp_grant0", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk); #1;
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, 64'hF0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("bp_hold_valid", resp_valid, 1);
         chk("bp_hold_data", resp_data, 64'hF0);
         chk("bp_no_ready", req0_ready | req1_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk); #1;
      chk("bp_released", resp_valid, 0);
      chk("bp_accept_again", req1_ready, 1);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk); #1;
      chk("bp_next_data", resp_data, 64'h30);
      chk("bp_next_id", resp_id, 1);

      // reset while EXEC: op dropped, arbiter back to favouring req0
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      do_op('{1'b1, 64'h8000_0000_0000_0000, 64'd1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 2'd1});
      set_req(1'b0, 1'b1, 64'd1, 64'd2, 2'b00);
      wait_grant(r);
      chk("mid_grant0", r, 0);
      @(negedge clk);
      reset = 1'b1;
      set_req(1'b1, 1'b1, 64'd10, 64'd20, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_resp_valid", resp_valid, 0);
      chk("mid_ovf_count", ovf_count, 0);
      chk("mid_alu_a", alu_a, 0);
      chk("mid_resp_data", resp_data, 0);
      chk("mid_tie_req0", req0_ready, 1);
      chk("mid_tie_req1", req1_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1 chk("mid_exec_no_valid", resp_valid, 0);
      @(negedge clk); #1;
      chk("mid_after_valid", resp_valid, 1);
      chk("mid_after_data", resp_data, 64'd3);
      chk("mid_after_id", resp_id, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
